// File: rtl/echo_heard_receiver_pkg.sv
// Shared definitions for the echo heard receiver slice.
// - RuleCount       : number of scheduler rules beyond bit 0 of rule_enable/rule_ready
// - MsgWidth        : width of one forwarded message word
// - Hdr*/Seq/Meth/V : bit offsets of the message fields
// - msg_t           : packed layout of a forwarded message
package echo_heard_receiver_pkg;

   localparam int unsigned RuleCount = 1;
   localparam int unsigned MsgWidth  = 96;

   localparam int unsigned HdrIdMsb = 95;
   localparam int unsigned SeqLsb   = 64;
   localparam int unsigned MethLsb  = 32;
   localparam int unsigned VLsb     = 0;

   typedef struct packed {
      logic [7:0]  id;
      logic [7:0]  rsvd;
      logic [15:0] seq;
      logic [31:0] meth;
      logic [31:0] v;
   } msg_t;

   function automatic logic [MsgWidth-1:0] pack_msg(input logic [7:0]  id,
                                                    input logic [15:0] seq,
                                                    input logic [31:0] meth,
                                                    input logic [31:0] v);
      msg_t m;
      m.id   = id;
      m.rsvd = 8'h00;
      m.seq  = seq;
      m.meth = meth;
      m.v    = v;
      return m;
   endfunction

endpackage

// File: rtl/echo_msg_fifo.sv
// Small synchronous FIFO holding heard messages until the forward rule takes them.
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset (storage cleared)
//   enq_i          write enq_data_i at the tail (caller guarantees !full_o)
//   enq_data_i     message to store
//   deq_i          drop the head entry (caller guarantees !empty_o)
//   first_o        head entry, combinational
//   full_o         all Depth entries occupied
//   empty_o        no entries occupied
module echo_msg_fifo #(
   parameter int unsigned Depth = 2,
   parameter int unsigned Width = 96
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             enq_i,
   input  logic [Width-1:0] enq_data_i,
   input  logic             deq_i,
   output logic [Width-1:0] first_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int unsigned IdxW = $clog2(Depth);
   localparam int unsigned PtrW = IdxW + 1;

   // Extra MSB on each pointer distinguishes full from empty when the indices match.
   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [Width-1:0] mem_q [Depth];
   logic [Width-1:0] mem_d [Depth];

   logic [IdxW-1:0] wr_idx;
   logic [IdxW-1:0] rd_idx;

   assign wr_idx = wr_ptr_q[IdxW-1:0];
   assign rd_idx = rd_ptr_q[IdxW-1:0];

   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[PtrW-1] != rd_ptr_q[PtrW-1]) &&
                    (wr_ptr_q[IdxW-1:0] == rd_ptr_q[IdxW-1:0]);
   assign first_o = mem_q[rd_idx];

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (enq_i) begin
         mem_d[wr_idx] = enq_data_i;
         wr_ptr_d      = wr_ptr_q + PtrW'(1);
      end
      if (deq_i) begin
         rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         for (int i = 0; i < Depth; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         mem_q    <= mem_d;
      end
   end

endmodule

// File: rtl/echo_heard_receiver.sv
// Receiving end of the heard(meth,v) indication. Each accepted call is stamped with MSG_ID and a
// 16-bit sequence number, buffered, and forwarded as one 96-bit word through pipe_enq when the
// scheduler enables the forward rule.
// Ports:
//   CLK, nRST       clock, asynchronous active-low reset
//   heard__ENA      caller enable, honoured only while heard__RDY=1
//   heard_meth/_v   heard arguments
//   heard__RDY      FIFO has room
//   pipe_enq__ENA   forward rule fires this cycle
//   pipe_enq_v      {MSG_ID, 8'h00, seq, meth, v} of the head entry
//   pipe_enq__RDY   downstream can take a word
//   msg_count       messages forwarded since reset (wraps)
//   rule_enable     bit 0 enables the forward rule
//   rule_ready      bit 0 is the forward rule guard; upper bits 0
module echo_heard_receiver
   import echo_heard_receiver_pkg::*;
#(
   parameter int unsigned DEPTH  = 2,
   parameter logic [7:0]  MSG_ID = 8'h01
) (
   input  logic                CLK,
   input  logic                nRST,
   input  logic                heard__ENA,
   input  logic [31:0]         heard_meth,
   input  logic [31:0]         heard_v,
   output logic                heard__RDY,
   output logic                pipe_enq__ENA,
   output logic [MsgWidth-1:0] pipe_enq_v,
   input  logic                pipe_enq__RDY,
   output logic [31:0]         msg_count,
   input  logic [RuleCount:0]  rule_enable,
   output logic [RuleCount:0]  rule_ready
);

   logic [15:0] seq_q, seq_d;
   logic [31:0] msg_count_q, msg_count_d;

   logic                acc;
   logic                fwd;
   logic                guard;
   logic                fifo_full;
   logic                fifo_empty;
   logic [MsgWidth-1:0] fifo_first;
   logic [MsgWidth-1:0] enq_word;

   // Only bit 0 is used by this block; the rest belong to other rules.
   logic unused_rule_enable;
   assign unused_rule_enable = ^rule_enable[RuleCount:1];

   assign heard__RDY = !fifo_full;
   assign acc        = heard__ENA && !fifo_full;
   assign guard      = !fifo_empty && pipe_enq__RDY;
   assign fwd        = rule_enable[0] && guard;
   assign enq_word   = pack_msg(MSG_ID, seq_q, heard_meth, heard_v);

   assign pipe_enq__ENA = fwd;
   assign pipe_enq_v    = fifo_first;
   assign msg_count     = msg_count_q;

   always_comb begin
      rule_ready    = '0;
      rule_ready[0] = guard;
   end

   always_comb begin
      seq_d       = seq_q;
      msg_count_d = msg_count_q;
      if (acc) begin
         seq_d = seq_q + 16'd1;
      end
      if (fwd) begin
         msg_count_d = msg_count_q + 32'd1;
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         seq_q       <= '0;
         msg_count_q <= '0;
      end else begin
         seq_q       <= seq_d;
         msg_count_q <= msg_count_d;
      end
   end

   // No bypass: a message accepted this cycle is visible at the head next cycle at the earliest.
   echo_msg_fifo #(
      .Depth (DEPTH),
      .Width (MsgWidth)
   ) u_fifo (
      .clk_i      (CLK),
      .rst_ni     (nRST),
      .enq_i      (acc),
      .enq_data_i (enq_word),
      .deq_i      (fwd),
      .first_o    (fifo_first),
      .full_o     (fifo_full),
      .empty_o    (fifo_empty)
   );

endmodule

// File: tb/tb_echo_heard_receiver.sv
module tb_echo_heard_receiver;

   localparam int unsigned DEPTH  = 2;
   localparam logic [7:0]  MSG_ID = 8'h01;

   logic        clk;
   logic        nrst;
   logic        heard_ena;
   logic [31:0] meth;
   logic [31:0] v;
   logic        heard_rdy;
   logic        enq_ena;
   logic [95:0] enq_v;
   logic        enq_rdy;
   logic [31:0] msg_count;
   logic [1:0]  rule_enable;
   logic [1:0]  rule_ready;

   int checks = 0;
   int errors = 0;

   // Reference model: queue of expected words plus counters.
   logic [95:0] ref_q[$];
   logic [15:0] ref_seq;
   logic [31:0] ref_count;
   bit          capture;
   logic [15:0] seen_seq[$];
   logic [95:0] last_fwd;

   echo_heard_receiver #(
      .DEPTH  (DEPTH),
      .MSG_ID (MSG_ID)
   ) dut (
      .CLK           (clk),
      .nRST          (nrst),
      .heard__ENA    (heard_ena),
      .heard_meth    (meth),
      .heard_v       (v),
      .heard__RDY    (heard_rdy),
      .pipe_enq__ENA (enq_ena),
      .pipe_enq_v    (enq_v),
      .pipe_enq__RDY (enq_rdy),
      .msg_count     (msg_count),
      .rule_enable   (rule_enable),
      .rule_ready    (rule_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      ref_q.delete();
      ref_seq   = 16'h0;
      ref_count = 32'h0;
   endtask

   // One clock cycle: drive after negedge, check combinational outputs, then update the model.
   task automatic cycle(input logic ena, input logic [31:0] m, input logic [31:0] vv,
                        input logic prdy, input logic [1:0] ren);
      bit exp_rdy, exp_guard, exp_fwd, exp_acc;
      @(negedge clk);
      heard_ena   = ena;
      meth        = m;
      v           = vv;
      enq_rdy     = prdy;
      rule_enable = ren;
      #1;
      exp_rdy   = ref_q.size() < DEPTH;
      exp_guard = (ref_q.size() != 0) && prdy;
      exp_fwd   = exp_guard && ren[0];
      exp_acc   = ena && exp_rdy;
      chk("heard_rdy", 96'(heard_rdy), 96'(exp_rdy));
      chk("rule_ready", 96'(rule_ready), 96'({1'b0, exp_guard}));
      chk("enq_ena", 96'(enq_ena), 96'(exp_fwd));
      if (ref_q.size() != 0) chk("enq_v", enq_v, ref_q[0]);
      if (exp_fwd) begin
         last_fwd = enq_v;
         if (capture) seen_seq.push_back(enq_v[79:64]);
      end
      @(posedge clk);
      if (exp_fwd) begin
         void'(ref_q.pop_front());
         ref_count++;
      end
      if (exp_acc) begin
         ref_q.push_back({MSG_ID, 8'h00, ref_seq, m, vv});
         ref_seq++;
      end
      #1;
      chk("msg_count", 96'(msg_count), 96'(ref_count));
   endtask

   task automatic drain();
      for (int i = 0; i < 2 * DEPTH; i++) cycle(1'b0, 32'h0, 32'h0, 1'b1, 2'b01);
   endtask

   initial begin
      logic [15:0] base;
      int unsigned n;
      heard_ena   = 1'b0;
      meth        = '0;
      v           = '0;
      enq_rdy     = 1'b0;
      rule_enable = 2'b00;
      capture     = 1'b0;
      last_fwd    = '0;
      model_reset();

      // Reset held for 3 cycles.
      nrst = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      enq_rdy     = 1'b1;
      rule_enable = 2'b01;
      #1;
      chk("rst_heard_rdy", 96'(heard_rdy), 96'(1'b1));
      chk("rst_enq_ena", 96'(enq_ena), 96'(1'b0));
      chk("rst_msg_count", 96'(msg_count), 96'h0);
      chk("rst_rule_ready", 96'(rule_ready), 96'h0);
      chk("rst_enq_v", enq_v, 96'h0);
      nrst = 1'b1;

      // Single message.
      cycle(1'b1, 32'hA, 32'h1234, 1'b1, 2'b01);
      cycle(1'b0, 32'h0, 32'h0, 1'b1, 2'b01);
      chk("single_word", last_fwd, 96'h01000000_0000000A_00001234);
      chk("single_count", 96'(msg_count), 96'd1);

      // Backpressure until full, third call ignored.
      base = ref_seq;
      capture = 1'b1;
      seen_seq.delete();
      for (int i = 0; i < 3; i++) cycle(1'b1, $urandom, $urandom, 1'b0, 2'b01);
      chk("full_rdy", 96'(heard_rdy), 96'(1'b0));
      for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 32'h0, 1'b1, 2'b01);
      chk("bp_words", 96'(seen_seq.size()), 96'd2);
      chk("bp_seq0", 96'(seen_seq[0]), 96'(base));
      chk("bp_seq1", 96'(seen_seq[1]), 96'(base + 16'd1));

      // Streaming for 20 cycles, then hold with rule disabled, then drain.
      base = ref_seq;
      seen_seq.delete();
      for (int i = 0; i < 20; i++) cycle(1'b1, $urandom, $urandom, 1'b1, 2'b01);
      chk("stream_words", 96'(seen_seq.size()), 96'd19);
      for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 32'h0, 1'b1, 2'b00);
      drain();
      chk("stream_total", 96'(seen_seq.size()), 96'd20);
      for (int i = 0; i < 20; i++) chk("stream_seq", 96'(seen_seq[i]), 96'(base + 16'(i)));
      capture = 1'b0;

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         cycle(1'($urandom), $urandom, $urandom, 1'($urandom_range(0, 3) != 0),
               2'($urandom));
      end
      drain();

      // Reset in the middle of a cycle with two entries buffered.
      cycle(1'b1, $urandom, $urandom, 1'b0, 2'b01);
      cycle(1'b1, $urandom, $urandom, 1'b0, 2'b01);
      @(negedge clk);
      heard_ena   = 1'b0;
      enq_rdy     = 1'b1;
      rule_enable = 2'b01;
      #1;
      chk("pre_rst_ena", 96'(enq_ena), 96'(1'b1));
      nrst = 1'b0;
      #1;
      chk("midrst_ena", 96'(enq_ena), 96'(1'b0));
      chk("midrst_v", enq_v, 96'h0);
      chk("midrst_count", 96'(msg_count), 96'h0);
      chk("midrst_rdy", 96'(heard_rdy), 96'(1'b1));
      chk("midrst_rule_ready", 96'(rule_ready), 96'h0);
      #1;
      nrst = 1'b1;
      model_reset();
      capture = 1'b1;
      seen_seq.delete();
      cycle(1'b1, 32'h55, 32'h66, 1'b1, 2'b01);
      cycle(1'b0, 32'h0, 32'h0, 1'b1, 2'b01);
      chk("post_rst_seq", 96'(seen_seq[0]), 96'h0);
      chk("post_rst_count", 96'(msg_count), 96'd1);
      capture = 1'b0;

      // Sequence wrap: stream until the next seq is FFFE, then three more.
      n = 32'(16'hFFFE - ref_seq);
      for (int unsigned i = 0; i < n; i++) cycle(1'b1, i, ~i, 1'b1, 2'b01);
      drain();
      capture = 1'b1;
      seen_seq.delete();
      for (int i = 0; i < 3; i++) cycle(1'b1, $urandom, $urandom, 1'b1, 2'b01);
      drain();
      chk("wrap_words", 96'(seen_seq.size()), 96'd3);
      chk("wrap_fffe", 96'(seen_seq[0]), 96'hFFFE);
      chk("wrap_ffff", 96'(seen_seq[1]), 96'hFFFF);
      chk("wrap_0000", 96'(seen_seq[2]), 96'h0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
